// File: rtl/counter_b4_pkg.sv
// Shared definitions for the 4-bit mode counter and its receiving-end monitor.
package counter_b4_pkg;

  localparam logic [1:0] MODE_UP  = 2'b00;
  localparam logic [1:0] MODE_DN  = 2'b01;
  localparam logic [1:0] MODE_UP3 = 2'b10;
  localparam logic [1:0] MODE_LD  = 2'b11;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    TRACK  = 2'd1,
    FAULT  = 2'd2
  } mon_state_e;

  // Bit positions inside mon_err_code.
  localparam int ERR_Q    = 0;
  localparam int ERR_RCO  = 1;
  localparam int ERR_LOAD = 2;

endpackage

// File: rtl/counter_b4_model.sv
// Combinational next-state predictor of the 4-bit mode counter (reset > enable > mode).
module counter_b4_model
  import counter_b4_pkg::*;
(
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic [3:0] d,
  input  logic [3:0] q,
  output logic [3:0] q_nxt,
  output logic       rco_nxt,
  output logic       load_nxt
);

  always_comb begin
    q_nxt    = q;
    rco_nxt  = 1'b0;
    load_nxt = 1'b0;
    if (rst) begin
      q_nxt = 4'd0;
    end else if (en) begin
      case (mode)
        MODE_UP: begin
          q_nxt   = q + 4'd1;
          rco_nxt = (q == 4'hF);
        end
        MODE_DN: begin
          q_nxt   = q - 4'd1;
          rco_nxt = (q == 4'h0);
        end
        MODE_UP3: begin
          q_nxt   = q + 4'd3;
          rco_nxt = (q >= 4'hD);
        end
        default: begin
          q_nxt    = d;
          load_nxt = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/counter_b4_monitor.sv
// Passive checker beside the 4-bit mode counter: predicts Q/rco/load one edge ahead,
// compares against the counter's outputs, and counts mismatches and rco pulses.
module counter_b4_monitor
  import counter_b4_pkg::*;
#(
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 8
) (
  input  logic              b4_clk,
  input  logic              b4_reset_mon,
  input  logic              b4_reset,
  input  logic              b4_enable,
  input  logic [1:0]        b4_mode,
  input  logic [3:0]        b4_D,
  input  logic [3:0]        b4_Q,
  input  logic              b4_rco,
  input  logic              b4_load,
  output logic              mon_synced,
  output logic              mon_error,
  output logic [2:0]        mon_err_code,
  output logic [ERR_W-1:0]  mon_err_count,
  output logic [WRAP_W-1:0] mon_wrap_count,
  output logic [3:0]        mon_expected_q
);

  mon_state_e        state_q, state_d;
  logic [3:0]        exp_cnt_q, exp_cnt_d;
  logic              exp_rco_q, exp_rco_d;
  logic              exp_load_q, exp_load_d;
  logic              synced_q, synced_d;
  logic              error_q, error_d;
  logic [2:0]        err_code_q, err_code_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic [WRAP_W-1:0] wrap_count_q, wrap_count_d;

  logic [3:0] mdl_q;
  logic       mdl_rco;
  logic       mdl_load;
  logic [2:0] mis;
  logic       seed;
  logic       take;

  counter_b4_model u_model (
    .rst      (b4_reset),
    .en       (b4_enable),
    .mode     (b4_mode),
    .d        (b4_D),
    .q        (b4_Q),
    .q_nxt    (mdl_q),
    .rco_nxt  (mdl_rco),
    .load_nxt (mdl_load)
  );

  always_comb begin
    mis           = 3'b000;
    mis[ERR_Q]    = (b4_Q != exp_cnt_q);
    mis[ERR_RCO]  = (b4_rco != exp_rco_q);
    mis[ERR_LOAD] = (b4_load != exp_load_q);
    seed          = b4_reset | (b4_enable & (b4_mode == MODE_LD));

    take         = 1'b0;
    state_d      = state_q;
    exp_cnt_d    = exp_cnt_q;
    exp_rco_d    = exp_rco_q;
    exp_load_d   = exp_load_q;
    error_d      = error_q;
    err_code_d   = err_code_q;
    err_count_d  = err_count_q;
    wrap_count_d = wrap_count_q + {{(WRAP_W-1){1'b0}}, b4_rco};

    case (state_q)
      UNSYNC: begin
        // Only a reset or a load makes the counter value knowable.
        if (seed) begin
          state_d = TRACK;
          take    = 1'b1;
        end
      end
      TRACK: begin
        take = 1'b1;
        if (|mis) begin
          state_d    = FAULT;
          error_d    = 1'b1;
          err_code_d = mis;
          if (~&err_count_q) begin
            err_count_d = err_count_q + {{(ERR_W-1){1'b0}}, 1'b1};
          end
        end
      end
      FAULT: begin
        state_d = TRACK;
        take    = 1'b1;
      end
      default: state_d = UNSYNC;
    endcase

    if (take) begin
      exp_cnt_d  = mdl_q;
      exp_rco_d  = mdl_rco;
      exp_load_d = mdl_load;
    end
    synced_d = (state_d != UNSYNC);
  end

  always_ff @(posedge b4_clk or posedge b4_reset_mon) begin
    if (b4_reset_mon) begin
      state_q      <= UNSYNC;
      exp_cnt_q    <= 4'd0;
      exp_rco_q    <= 1'b0;
      exp_load_q   <= 1'b0;
      synced_q     <= 1'b0;
      error_q      <= 1'b0;
      err_code_q   <= 3'b000;
      err_count_q  <= '0;
      wrap_count_q <= '0;
    end else begin
      state_q      <= state_d;
      exp_cnt_q    <= exp_cnt_d;
      exp_rco_q    <= exp_rco_d;
      exp_load_q   <= exp_load_d;
      synced_q     <= synced_d;
      error_q      <= error_d;
      err_code_q   <= err_code_d;
      err_count_q  <= err_count_d;
      wrap_count_q <= wrap_count_d;
    end
  end

  assign mon_synced     = synced_q;
  assign mon_error      = error_q;
  assign mon_err_code   = err_code_q;
  assign mon_err_count  = err_count_q;
  assign mon_wrap_count = wrap_count_q;
  assign mon_expected_q = exp_cnt_q;

endmodule

// File: tb/tb_counter_b4_monitor.sv
// Bench for counter_b4_monitor: a behavioural counter drives the checked outputs,
// with per-cycle overrides to inject faults; expected monitor outputs come from a table.
module tb_counter_b4_monitor;

  localparam int ERR_W  = 8;
  localparam int WRAP_W = 8;
  localparam logic [1:0] UP = 2'b00, DN = 2'b01, UP3 = 2'b10, LD = 2'b11;

  logic              b4_clk       = 1'b0;
  logic              b4_reset_mon = 1'b1;
  logic              b4_reset     = 1'b0;
  logic              b4_enable    = 1'b0;
  logic [1:0]        b4_mode      = 2'b00;
  logic [3:0]        b4_D         = 4'd0;
  logic [3:0]        b4_Q;
  logic              b4_rco;
  logic              b4_load;
  logic              mon_synced;
  logic              mon_error;
  logic [2:0]        mon_err_code;
  logic [ERR_W-1:0]  mon_err_count;
  logic [WRAP_W-1:0] mon_wrap_count;
  logic [3:0]        mon_expected_q;

  // Behavioural counter plus fault-injection overrides.
  logic [3:0] cnt_r  = 4'd0;
  logic       rco_r  = 1'b0;
  logic       load_r = 1'b0;
  logic       iq = 1'b0, ir = 1'b0, il = 1'b0;
  logic [3:0] qv = 4'd0;

  assign b4_Q    = iq ? qv : cnt_r;
  assign b4_rco  = ir | rco_r;
  assign b4_load = il | load_r;

  always #5 b4_clk = ~b4_clk;

  always @(posedge b4_clk) begin : ref_ctr
    int nx;
    if (b4_reset) begin
      cnt_r <= 4'd0; rco_r <= 1'b0; load_r <= 1'b0;
    end else if (!b4_enable) begin
      cnt_r <= b4_Q; rco_r <= 1'b0; load_r <= 1'b0;
    end else if (b4_mode == LD) begin
      cnt_r <= b4_D; rco_r <= 1'b0; load_r <= 1'b1;
    end else begin
      nx = int'(b4_Q) + ((b4_mode == UP) ? 1 : (b4_mode == DN) ? -1 : 3);
      cnt_r  <= nx[3:0];
      rco_r  <= (nx > 15) || (nx < 0);
      load_r <= 1'b0;
    end
  end

  counter_b4_monitor #(.ERR_W(ERR_W), .WRAP_W(WRAP_W)) dut (
    .b4_clk         (b4_clk),
    .b4_reset_mon   (b4_reset_mon),
    .b4_reset       (b4_reset),
    .b4_enable      (b4_enable),
    .b4_mode        (b4_mode),
    .b4_D           (b4_D),
    .b4_Q           (b4_Q),
    .b4_rco         (b4_rco),
    .b4_load        (b4_load),
    .mon_synced     (mon_synced),
    .mon_error      (mon_error),
    .mon_err_code   (mon_err_code),
    .mon_err_count  (mon_err_count),
    .mon_wrap_count (mon_wrap_count),
    .mon_expected_q (mon_expected_q)
  );

  typedef struct {
    logic       rst, en;
    logic [1:0] mode;
    logic [3:0] d;
    logic       iq;
    logic [3:0] qv;
    logic       ir, il;
    logic       syn, err;
    logic [2:0] code;
    logic [7:0] ecnt, wcnt;
    logic [3:0] eq;
  } vec_t;

  typedef struct {
    logic       syn, err;
    logic [2:0] code;
    logic [7:0] ecnt, wcnt;
    logic [3:0] eq;
  } exp_t;

  exp_t sb[$];
  vec_t tbl [28];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic rst, input logic en, input logic [1:0] mode,
                              input logic [3:0] d, input logic fq, input logic [3:0] fv,
                              input logic fr, input logic fl, input logic syn, input logic err,
                              input logic [2:0] code, input logic [7:0] ecnt,
                              input logic [7:0] wcnt, input logic [3:0] eq);
    vec_t v;
    v.rst = rst; v.en = en; v.mode = mode; v.d = d;
    v.iq = fq; v.qv = fv; v.ir = fr; v.il = fl;
    v.syn = syn; v.err = err; v.code = code; v.ecnt = ecnt; v.wcnt = wcnt; v.eq = eq;
    return v;
  endfunction

  task automatic chk(input string tag, input string f, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s.%s: got %0h, expected %0h", tag, f, act, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, "synced",   32'(mon_synced),     32'd0);
    chk(tag, "error",    32'(mon_error),      32'd0);
    chk(tag, "err_code", 32'(mon_err_code),   32'd0);
    chk(tag, "err_cnt",  32'(mon_err_count),  32'd0);
    chk(tag, "wrap_cnt", 32'(mon_wrap_count), 32'd0);
    chk(tag, "exp_q",    32'(mon_expected_q), 32'd0);
  endtask

  task automatic cyc(input vec_t v, input string tag);
    exp_t e;
    b4_reset = v.rst; b4_enable = v.en; b4_mode = v.mode; b4_D = v.d;
    iq = v.iq; qv = v.qv; ir = v.ir; il = v.il;
    e.syn = v.syn; e.err = v.err; e.code = v.code; e.ecnt = v.ecnt; e.wcnt = v.wcnt; e.eq = v.eq;
    sb.push_back(e);
    @(posedge b4_clk);
    #1;
    e = sb.pop_front();
    chk(tag, "synced",   32'(mon_synced),     32'(e.syn));
    chk(tag, "error",    32'(mon_error),      32'(e.err));
    chk(tag, "err_code", 32'(mon_err_code),   32'(e.code));
    chk(tag, "err_cnt",  32'(mon_err_count),  32'(e.ecnt));
    chk(tag, "wrap_cnt", 32'(mon_wrap_count), 32'(e.wcnt));
    chk(tag, "exp_q",    32'(mon_expected_q), 32'(e.eq));
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) cyc(tbl[i], $sformatf("tbl%0d", i));
  endtask

  task automatic pulse_mon_reset(input string tag);
    #3 b4_reset_mon = 1'b1;
    #1 chk_zero(tag);
    #1 b4_reset_mon = 1'b0;
  endtask

  initial begin
    //          rst en mode d     iq qv    ir il  syn err code    ecnt   wcnt  eq
    tbl[0]  = mk(0, 1, LD,  4'hD, 0, 4'h0, 0, 0,  1,  0, 3'b000, 8'd0,   8'd1, 4'hD);
    tbl[1]  = mk(0, 1, UP3, 4'h0, 0, 4'h0, 0, 0,  1,  0, 3'b000, 8'd0,   8'd1, 4'h0);
    tbl[2]  = mk(0, 1, UP3, 4'h0, 0, 4'h0, 0, 0,  1,  0, 3'b000, 8'd0,   8'd2, 4'h3);
    tbl[3]  = mk(0, 1, UP,  4'h0, 0, 4'h0, 0, 0,  1,  0, 3'b000, 8'd0,   8'd2, 4'h4);
    tbl[4]  = mk(0, 1, UP,  4'h0, 0, 4'h0, 0, 0,  1,  0, 3'b000, 8'd0,   8'd2, 4'h5);
    tbl[5]  = mk(0, 1, UP,  4'h0, 0, 4'h0, 0, 0,  1,  0, 3'b000, 8'd0,   8'd2, 4'h6);
    tbl[6]  = mk(0, 1, UP,  4'h0, 1, 4'h5, 0, 0,  1,  1, 3'b001, 8'd1,   8'd2, 4'h6);
    tbl[7]  = mk(0, 1, UP,  4'h0, 0, 4'h0, 0, 0,  1,  1, 3'b001, 8'd1,   8'd2, 4'h7);
    tbl[8]  = mk(0, 1, UP,  4'h0, 0, 4'h0, 0, 0,  1,  1, 3'b001, 8'd1,   8'd2, 4'h8);
    tbl[9]  = mk(0, 0, UP,  4'h0, 0, 4'h0, 1, 0,  1,  1, 3'b010, 8'd2,   8'd3, 4'h8);
    tbl[10] = mk(0, 0, UP,  4'h0, 0, 4'h0, 0, 0,  1,  1, 3'b010, 8'd2,   8'd3, 4'h8);
    tbl[11] = mk(0, 0, UP,  4'h0, 0, 4'h0, 0, 0,  1,  1, 3'b010, 8'd2,   8'd3, 4'h8);
    tbl[12] = mk(0, 1, LD,  4'h1, 0, 4'h0, 0, 0,  1,  1, 3'b010, 8'd2,   8'd3, 4'h1);
    tbl[13] = mk(0, 1, DN,  4'h0, 0, 4'h0, 0, 0,  1,  1, 3'b010, 8'd2,   8'd3, 4'h0);
    tbl[14] = mk(0, 1, DN,  4'h0, 0, 4'h0, 0, 0,  1,  1, 3'b010, 8'd2,   8'd3, 4'hF);
    tbl[15] = mk(0, 1, DN,  4'h0, 0, 4'h0, 0, 0,  1,  1, 3'b010, 8'd2,   8'd4, 4'hE);
    // after error saturation
    tbl[16] = mk(0, 0, UP,  4'h0, 0, 4'h0, 1, 0,  1,  1, 3'b010, 8'd255, 8'd5, 4'h6);
    tbl[17] = mk(0, 0, UP,  4'h0, 0, 4'h0, 0, 0,  1,  1, 3'b010, 8'd255, 8'd5, 4'h6);
    tbl[18] = mk(0, 0, UP,  4'h0, 0, 4'h0, 0, 1,  1,  1, 3'b100, 8'd255, 8'd5, 4'h6);
    tbl[19] = mk(0, 0, UP,  4'h0, 0, 4'h0, 0, 0,  1,  1, 3'b100, 8'd255, 8'd5, 4'h6);
    tbl[20] = mk(1, 1, UP,  4'h0, 0, 4'h0, 0, 0,  1,  1, 3'b100, 8'd255, 8'd5, 4'h0);
    tbl[21] = mk(0, 1, UP,  4'h0, 0, 4'h0, 0, 0,  1,  1, 3'b100, 8'd255, 8'd5, 4'h1);
    // after a monitor reset in TRACK: unsynced until a load
    tbl[22] = mk(0, 1, UP,  4'h0, 1, 4'h9, 0, 0,  0,  0, 3'b000, 8'd0,   8'd0, 4'h0);
    tbl[23] = mk(0, 1, UP,  4'h0, 0, 4'h0, 0, 0,  0,  0, 3'b000, 8'd0,   8'd0, 4'h0);
    tbl[24] = mk(0, 1, LD,  4'h2, 0, 4'h0, 0, 0,  1,  0, 3'b000, 8'd0,   8'd0, 4'h2);
    tbl[25] = mk(0, 1, UP,  4'h0, 0, 4'h0, 0, 0,  1,  0, 3'b000, 8'd0,   8'd0, 4'h3);
    tbl[26] = mk(0, 1, UP,  4'h0, 1, 4'h7, 0, 0,  1,  1, 3'b001, 8'd1,   8'd0, 4'h8);
    // after a monitor reset in FAULT
    tbl[27] = mk(0, 0, UP,  4'h0, 0, 4'h0, 0, 0,  0,  0, 3'b000, 8'd0,   8'd0, 4'h0);

    #2 chk_zero("por");
    @(posedge b4_clk);
    #1 b4_reset_mon = 1'b0;

    cyc(mk(1, 0, UP, 4'h0, 0, 4'h0, 0, 0, 1, 0, 3'b000, 8'd0, 8'd0, 4'h0), "ctr_rst");
    for (int i = 0; i < 20; i++)
      cyc(mk(0, 1, UP, 4'h0, 0, 4'h0, 0, 0, 1, 0, 3'b000, 8'd0,
             (i >= 16) ? 8'd1 : 8'd0, 4'((i + 1) % 16)), $sformatf("up%0d", i));

    run(0, 15);

    // 300 Q mismatches: every injected value differs from the previous one,
    // and only every second cycle is compared (FAULT skips).
    for (int k = 0; k < 600; k++) begin
      automatic logic [3:0] v = 4'((15 + k) % 16);
      automatic int       ec = (3 + k / 2 > 255) ? 255 : 3 + k / 2;
      cyc(mk(0, 0, UP, 4'h0, 1, v, 0, 0, 1, 1, 3'b001, 8'(ec), 8'd4, v), $sformatf("sat%0d", k));
    end

    run(16, 21);
    pulse_mon_reset("mon_rst_track");
    run(22, 26);
    pulse_mon_reset("mon_rst_fault");
    run(27, 27);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
